// File: rtl/btn_guess_capture.sv
// Push-button front-end: synchronise, debounce and edge-detect N buttons, then buffer the
// highest-priority new press as a guess code for the game controller.
module btn_guess_capture #(
    parameter int unsigned NUM_BTN  = 5,
    parameter int unsigned CODE_W   = 3,
    parameter int unsigned TICK_W   = 17,
    parameter int unsigned STABLE_N = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               sw_rst,
    input  logic               arm,
    input  logic               guess_ack,
    output logic [CODE_W-1:0]  guess_code,
    output logic               guess_valid,
    output logic               dropped,
    output logic [NUM_BTN-1:0] btn_level,
    output logic               soft_rst
);

    localparam logic [CODE_W-1:0] NoCode    = CODE_W'(NUM_BTN);
    localparam logic [3:0]        StableCnt = 4'(STABLE_N);

    logic [NUM_BTN-1:0]      btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic                    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    logic                    soft_rst_q, soft_rst_d;
    logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic                    tick;
    logic [NUM_BTN-1:0][3:0] db_cnt_q, db_cnt_d;
    logic [NUM_BTN-1:0]      level_q, level_d;
    logic [NUM_BTN-1:0]      level_prev_q, level_prev_d;
    logic [NUM_BTN-1:0]      rise_q, rise_d;
    logic                    hit;
    logic [CODE_W-1:0]       enc;
    logic [CODE_W-1:0]       code_q, code_d;
    logic                    valid_q, valid_d;
    logic                    dropped_q, dropped_d;
    logic                    take;

    always_comb begin
        btn_s1_d   = btn;
        btn_s2_d   = btn_s1_q;
        sw_s1_d    = sw_rst;
        sw_s2_d    = sw_s1_q;
        soft_rst_d = sw_s2_q;
        tick_cnt_d = tick_cnt_q + 1'b1;
    end

    // Tick fires in the cycle the counter is about to wrap back to zero.
    assign tick = &tick_cnt_q;

    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (tick) begin
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                if (btn_s2_q[i] != level_q[i]) begin
                    if (db_cnt_q[i] + 4'd1 >= StableCnt) begin
                        level_d[i]  = ~level_q[i];
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + 4'd1;
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
            end
        end
    end

    always_comb begin
        level_prev_d = level_q;
        rise_d       = level_q & ~level_prev_q;
    end

    // Scan downwards so the lowest set index wins.
    always_comb begin
        hit = |rise_q;
        enc = NoCode;
        for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
            if (rise_q[i]) begin
                enc = CODE_W'(i);
            end
        end
    end

    always_comb begin
        code_d    = code_q;
        valid_d   = valid_q;
        dropped_d = dropped_q;
        take      = hit && arm && (!valid_q || guess_ack);
        if (take) begin
            code_d  = enc;
            valid_d = 1'b1;
        end else begin
            if (hit && arm && valid_q) begin
                dropped_d = 1'b1;
            end
            if (guess_ack && valid_q) begin
                valid_d = 1'b0;
                code_d  = NoCode;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q     <= '0;
            btn_s2_q     <= '0;
            sw_s1_q      <= 1'b0;
            sw_s2_q      <= 1'b0;
            soft_rst_q   <= 1'b0;
            tick_cnt_q   <= '0;
            db_cnt_q     <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            rise_q       <= '0;
            code_q       <= NoCode;
            valid_q      <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            btn_s1_q     <= btn_s1_d;
            btn_s2_q     <= btn_s2_d;
            sw_s1_q      <= sw_s1_d;
            sw_s2_q      <= sw_s2_d;
            soft_rst_q   <= soft_rst_d;
            tick_cnt_q   <= tick_cnt_d;
            db_cnt_q     <= db_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            rise_q       <= rise_d;
            code_q       <= code_d;
            valid_q      <= valid_d;
            dropped_q    <= dropped_d;
        end
    end

    assign guess_code  = code_q;
    assign guess_valid = valid_q;
    assign dropped     = dropped_q;
    assign btn_level   = level_q;
    assign soft_rst    = soft_rst_q;

endmodule

// File: tb/tb_btn_guess_capture.sv
// Directed bench for btn_guess_capture with a fast tick (TICK_W=2) and STABLE_N=3.
module tb_btn_guess_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] btn;
    logic       sw_rst;
    logic       arm;
    logic       guess_ack;
    logic [2:0] guess_code;
    logic       guess_valid;
    logic       dropped;
    logic [4:0] btn_level;
    logic       soft_rst;

    int n_vec = 0;
    int n_err = 0;
    int cap_cnt = 0;
    logic prev_valid = 1'b0;

    btn_guess_capture #(
        .NUM_BTN (5),
        .CODE_W  (3),
        .TICK_W  (2),
        .STABLE_N(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .sw_rst     (sw_rst),
        .arm        (arm),
        .guess_ack  (guess_ack),
        .guess_code (guess_code),
        .guess_valid(guess_valid),
        .dropped    (dropped),
        .btn_level  (btn_level),
        .soft_rst   (soft_rst)
    );

    always #5 clk = ~clk;

    // Count 0->1 transitions of guess_valid.
    always @(negedge clk) begin
        if (guess_valid && !prev_valid) cap_cnt <= cap_cnt + 1;
        prev_valid <= guess_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n = 0;
        while (!guess_valid && n < max_cyc) begin
            step(1);
            n++;
        end
        check_eq(tag, {31'd0, guess_valid}, 32'd1);
    endtask

    task automatic ack_pulse();
        guess_ack = 1'b1;
        step(1);
        guess_ack = 1'b0;
    endtask

    initial begin
        int cap0;
        int n;
        logic bad;

        rst = 1'b1; btn = '0; sw_rst = 1'b0; arm = 1'b0; guess_ack = 1'b0;
        step(3);
        check_eq("rst_code", {29'd0, guess_code}, 32'd5);
        check_eq("rst_valid", {31'd0, guess_valid}, 32'd0);
        check_eq("rst_dropped", {31'd0, dropped}, 32'd0);
        check_eq("rst_level", {27'd0, btn_level}, 32'd0);
        check_eq("rst_soft", {31'd0, soft_rst}, 32'd0);
        rst = 1'b0;
        step(2);

        // Clean press on button 2.
        arm = 1'b1;
        cap0 = cap_cnt;
        btn[2] = 1'b1;
        wait_valid("clean_valid", 30);
        check_eq("clean_code", {29'd0, guess_code}, 32'd2);
        check_eq("clean_level", {27'd0, btn_level}, 32'b00100);
        step(15);
        check_eq("clean_hold_valid", {31'd0, guess_valid}, 32'd1);
        check_eq("clean_hold_code", {29'd0, guess_code}, 32'd2);
        btn[2] = 1'b0;
        step(25);
        check_eq("clean_once", cap_cnt - cap0, 32'd1);
        check_eq("clean_wait_ack", {31'd0, guess_valid}, 32'd1);
        ack_pulse();
        check_eq("clean_ack_valid", {31'd0, guess_valid}, 32'd0);
        check_eq("clean_ack_code", {29'd0, guess_code}, 32'd5);

        // Bouncing button 1: no level change while it chatters.
        cap0 = cap_cnt;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            btn[1] = ~btn[1];
            for (int j = 0; j < 3; j++) begin
                step(1);
                bad = bad | btn_level[1] | guess_valid;
            end
        end
        check_eq("bounce_quiet", {31'd0, bad}, 32'd0);
        btn[1] = 1'b1;
        wait_valid("bounce_valid", 40);
        check_eq("bounce_code", {29'd0, guess_code}, 32'd1);
        step(10);
        check_eq("bounce_once", cap_cnt - cap0, 32'd1);
        ack_pulse();
        btn[1] = 1'b0;
        step(25);

        // Simultaneous presses: lowest index wins, others discarded.
        btn[3] = 1'b1; btn[0] = 1'b1;
        wait_valid("simul_valid", 30);
        check_eq("simul_code", {29'd0, guess_code}, 32'd0);
        step(5);
        ack_pulse();
        step(5);
        check_eq("simul_no_second", {31'd0, guess_valid}, 32'd0);
        check_eq("simul_dropped", {31'd0, dropped}, 32'd0);
        btn = '0;
        step(25);

        // Overflow: second press while full sets dropped, code kept.
        btn[4] = 1'b1;
        wait_valid("ovf_valid", 30);
        check_eq("ovf_code4", {29'd0, guess_code}, 32'd4);
        btn[1] = 1'b1;
        step(30);
        check_eq("ovf_keep_code", {29'd0, guess_code}, 32'd4);
        check_eq("ovf_dropped", {31'd0, dropped}, 32'd1);
        btn = '0;
        step(25);
        // Ack in the rise cycle of a new press: new code replaces the old one.
        btn[3] = 1'b1;
        n = 0;
        while (!btn_level[3] && n < 30) begin
            step(1);
            n++;
        end
        check_eq("ovf_level3", {31'd0, btn_level[3]}, 32'd1);
        step(1);
        guess_ack = 1'b1;
        step(1);
        guess_ack = 1'b0;
        check_eq("ovf_ackcap_valid", {31'd0, guess_valid}, 32'd1);
        check_eq("ovf_ackcap_code", {29'd0, guess_code}, 32'd3);
        check_eq("ovf_dropped_sticky", {31'd0, dropped}, 32'd1);
        ack_pulse();
        check_eq("ovf_final_code", {29'd0, guess_code}, 32'd5);
        btn = '0;
        step(25);

        // Disarmed press is ignored, arming while held does not capture it.
        arm = 1'b0;
        btn[2] = 1'b1;
        step(25);
        check_eq("dis_valid", {31'd0, guess_valid}, 32'd0);
        check_eq("dis_level", {31'd0, btn_level[2]}, 32'd1);
        arm = 1'b1;
        step(10);
        check_eq("dis_arm_held", {31'd0, guess_valid}, 32'd0);
        btn[2] = 1'b0;
        step(25);
        btn[2] = 1'b1;
        wait_valid("dis_repress", 30);
        check_eq("dis_code", {29'd0, guess_code}, 32'd2);
        ack_pulse();
        btn[2] = 1'b0;
        step(25);

        // Reset with pending guess and button held.
        btn[0] = 1'b1;
        wait_valid("rst2_valid", 30);
        step(2);
        rst = 1'b1;
        step(1);
        check_eq("rst2_code", {29'd0, guess_code}, 32'd5);
        check_eq("rst2_valid", {31'd0, guess_valid}, 32'd0);
        check_eq("rst2_dropped", {31'd0, dropped}, 32'd0);
        check_eq("rst2_level", {27'd0, btn_level}, 32'd0);
        rst = 1'b0;
        wait_valid("rst2_recap", 40);
        check_eq("rst2_code0", {29'd0, guess_code}, 32'd0);
        ack_pulse();
        btn[0] = 1'b0;
        step(5);

        // Soft reset follows the switch after three clocks.
        sw_rst = 1'b1;
        step(2);
        check_eq("soft_early", {31'd0, soft_rst}, 32'd0);
        step(1);
        check_eq("soft_on", {31'd0, soft_rst}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
